// File: rtl/exynos_sequencer.sv
// Power-on/reset sequencer for the Exynos4412 CPU module, downstream of c66x_sequencer.
// Drives PMIC power-on, CPU/PMIC resets, bootmode strap window and USB hub reset.
module exynos_sequencer #(
  parameter int unsigned PWRON_CYCLES     = 16500,
  parameter int unsigned PMIC_WAIT_CYCLES = 110000,
  parameter int unsigned RESETOUT_TIMEOUT = 5500000,
  parameter int unsigned HUB_RESET_CYCLES = 55000,
  parameter int unsigned CNT_W            = 24
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       enable,
  input  logic       cpu_resetout,
  output logic       pmic_pwron,
  output logic       pmic_reset_INV,
  output logic       cpu_reset_INV,
  output logic       usbhub_reset_INV,
  output logic       bootmode_en,
  output logic       running,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StPwron    = 3'd1,
    StPmicWait = 3'd2,
    StCpuWait  = 3'd3,
    StHubReset = 3'd4,
    StRunning  = 3'd5,
    StFault    = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] PwronLast    = CNT_W'(PWRON_CYCLES - 1);
  localparam logic [CNT_W-1:0] PmicWaitLast = CNT_W'(PMIC_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast  = CNT_W'(RESETOUT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HubLast      = CNT_W'(HUB_RESET_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
  logic             timed, expired;
  logic             rso_meta_q, rso_s_q;
  // {pmic_pwron, pmic_reset_INV, cpu_reset_INV, usbhub_reset_INV, bootmode_en, running, fault}
  logic [6:0]       out_d, out_q;

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      rso_meta_q <= 1'b0;
      rso_s_q    <= 1'b0;
    end else begin
      rso_meta_q <= cpu_resetout;
      rso_s_q    <= rso_meta_q;
    end
  end

  always_comb begin
    timed    = 1'b0;
    cnt_last = '0;
    case (state_q)
      StPwron:    begin timed = 1'b1; cnt_last = PwronLast;    end
      StPmicWait: begin timed = 1'b1; cnt_last = PmicWaitLast; end
      StCpuWait:  begin timed = 1'b1; cnt_last = TimeoutLast;  end
      StHubReset: begin timed = 1'b1; cnt_last = HubLast;      end
      default:    ;
    endcase
  end

  assign expired = timed && (cnt_q == cnt_last);

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StOff;
    end else begin
      case (state_q)
        StOff:      state_d = StPwron;
        StPwron:    if (expired) state_d = StPmicWait;
        StPmicWait: if (expired) state_d = StCpuWait;
        StCpuWait: begin
          // RESETOUT arriving on the timeout cycle still counts as a good boot
          if (rso_s_q)      state_d = StHubReset;
          else if (expired) state_d = StFault;
        end
        StHubReset: if (expired) state_d = StRunning;
        StRunning:  if (!rso_s_q) state_d = StCpuWait;
        StFault:    state_d = StFault;
        default:    state_d = StOff;
      endcase
    end
  end

  assign cnt_d = (state_d != state_q || !timed) ? '0 : cnt_q + CNT_W'(1);

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_comb begin
    out_d = 7'b000_0000;
    case (state_d)
      StPwron:    out_d = 7'b110_0000;
      StPmicWait: out_d = 7'b010_0100;
      StCpuWait:  out_d = 7'b011_0100;
      StHubReset: out_d = 7'b011_0000;
      StRunning:  out_d = 7'b011_1010;
      StFault:    out_d = 7'b000_0001;
      default:    out_d = 7'b000_0000;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q <= StOff;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign {pmic_pwron, pmic_reset_INV, cpu_reset_INV, usbhub_reset_INV,
          bootmode_en, running, fault} = out_q;
  assign state = state_q;

endmodule
